// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM input capture block: FSM encoding and the
// saturation/timeout value for a given counter width.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  // All-ones value for a WIDTH-bit counter; doubles as the stuck timeout.
  function automatic logic [63:0] pwm_capture_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// Input synchroniser plus registered edge detector. rise/fall are registered
// one cycle after the level change is seen, and s is aligned with them.
module pwm_capture_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES:0]   vld;
  logic                   s_d;

  // vld tracks which stages hold real post-reset samples, so an input that is
  // already high at reset is never seen as a rise until it has been low.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      vld   <= '0;
      s_d   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pwm_in};
      vld   <= {vld[SYNC_STAGES-1:0], 1'b1};
      s_d   <= chain[SYNC_STAGES-1];
      rise  <= vld[SYNC_STAGES] &  chain[SYNC_STAGES-1] & ~s_d;
      fall  <= vld[SYNC_STAGES] & ~chain[SYNC_STAGES-1] &  s_d;
    end
  end

  assign s = s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of a synchronised PWM
// input, with sticky new_data/overrun flags and a stuck-input timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             clear,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] period,
  output logic             new_data,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] PWM_CAPTURE_MAX = WIDTH'(pwm_capture_max(WIDTH));

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, hi_cnt;
  logic             s, rise, fall;
  logic             timeout, commit, restart, latch_hi;

  pwm_capture_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_RISE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_RISE: if (rise) state_nx = HIGH;
      HIGH:      if (timeout) state_nx = WAIT_RISE; else if (fall) state_nx = LOW;
      LOW:       if (timeout) state_nx = WAIT_RISE; else if (rise) state_nx = HIGH;
      default:   state_nx = WAIT_RISE;
    endcase
  end

  // Timeout has priority over any edge arriving on the same cycle.
  always_comb begin
    timeout  = (state != WAIT_RISE) && (cnt == PWM_CAPTURE_MAX);
    commit   = (state == LOW) && rise && !timeout;
    restart  = ((state == WAIT_RISE) && rise) || commit;
    latch_hi = (state == HIGH) && fall && !timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      hi_cnt      <= '0;
      high_time   <= '0;
      period      <= '0;
      new_data    <= 1'b0;
      overrun     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      if (restart)
        cnt <= WIDTH'(1);
      else if ((state != WAIT_RISE) && (cnt != PWM_CAPTURE_MAX))
        cnt <= cnt + WIDTH'(1);
      if (latch_hi) hi_cnt <= cnt;
      if (commit) begin
        period    <= cnt;
        high_time <= hi_cnt;
        stuck     <= 1'b0;
      end
      if (timeout) begin
        period      <= PWM_CAPTURE_MAX;
        high_time   <= s ? PWM_CAPTURE_MAX : '0;
        stuck       <= 1'b1;
        stuck_level <= s;
      end
      new_data <= commit | timeout | (new_data & ~clear);
      overrun  <= ~clear & (overrun | ((commit | timeout) & new_data));
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input capture peripheral: the receive-side counterpart to the team's 8-bit PWM generator. It synchronises an external PWM signal and measures its high time and period in clock cycles. It also flags a stuck (edge-less) input and exposes results through simple status/clear signals for the peripheral register interface. A loopback of the generator into this block is the standard self-test path.

## Interface
Parameters:
- `WIDTH`, 16: width of the measurement counters and results; minimum 4.
- `SYNC_STAGES`, 2: flops in the input synchroniser; minimum 2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `pwm_in`  in  1: asynchronous PWM input.
- `clear`  in  1: one-cycle pulse; clears `new_data` and `overrun`.
- `high_time`  out  WIDTH: high cycles of the last complete period.
- `period`  out  WIDTH: cycles between the last two rising edges.
- `new_data`  out  1: sticky flag; results updated since the last `clear`.
- `overrun`  out  1: sticky flag; a result was committed while `new_data` was already set.
- `stuck`  out  1: no rising edge seen for 2^WIDTH−1 cycles.
- `stuck_level`  out  1: synchronised input level when `stuck` was asserted.

## Operation
- Input path:
  - `SYNC_STAGES` flop chain feeds a synchronised level `s`.
  - One extra register `s_d` provides edge detection: rise = `s & ~s_d`, fall = `~s & s_d`.
- FSM states:
  - WAIT_RISE: after reset or stuck. Counters are held; falls are ignored. On rise: counter = 1, go to HIGH.
  - HIGH: counter increments each cycle. On fall: latch `hi_cnt` = counter, go to LOW. On rise: not possible.
  - LOW: counter increments. On rise: commit, counter = 1, go to HIGH.
- Commit:
  - `period` ← counter, `high_time` ← `hi_cnt`.
  - `new_data` ← 1; `stuck` ← 0.
  - For an ideal input with H high cycles and period P (1 ≤ H < P < 2^WIDTH−1): `high_time` = H, `period` = P exactly.
- Timeout: in HIGH or LOW, if the counter reaches 2^WIDTH−1 (it saturates there):
  - `stuck` ← 1, `stuck_level` ← `s`.
  - `period` ← all-ones; `high_time` ← all-ones if `s` = 1, else 0.
  - `new_data` ← 1; go to WAIT_RISE.
  - Timeout is not evaluated in WAIT_RISE, so it fires at most once per stall.
- Flags:
  - `overrun` sets on any commit or timeout that occurs while `new_data` = 1 and `clear` = 0.
  - `clear` coincident with a commit: the commit wins. `new_data` = 1; `overrun` is unchanged apart from clearing, so it ends at 0.
- No glitch filtering: a one-cycle pulse after synchronisation is measured as H = 1.
- Reset values:
  - All outputs 0; FSM in WAIT_RISE.
  - Synchroniser, `s_d` and counters 0.
  - An input already high at reset is not counted as a rise until it has been low.
- Reset mid-measurement discards the partial period. No output changes except the return to reset values.

## Timing
- Latency from a `pwm_in` transition to the internal edge: SYNC_STAGES+1 clocks.
- Results and `new_data` update on the clock edge after the rise is detected. Total: SYNC_STAGES+2 clocks after the `pwm_in` rise completing the period.
- Timeout asserts exactly 2^WIDTH−1 cycles after the last detected rise.
- `clear` takes effect on the next edge. Outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum measurable: H = 1, P = 2. Back-to-back periods are captured with no dead cycles.

## Structure
- Shared package:
  - FSM state encoding (WAIT_RISE, HIGH, LOW).
  - A `PWM_CAPTURE_MAX` constant, function of WIDTH (all-ones).
- Sub-module `pwm_capture_sync`: the synchroniser plus edge detector. Outputs `s`, `rise`, `fall`; parameter `SYNC_STAGES`.
- Top level holds the FSM, counter, result and flag registers.

## Test plan
- Generator loopback, level 64, wrap 255 (H = 64, P = 255): after the second rise, `high_time` = 64, `period` = 255, `new_data` = 1, `stuck` = 0.
- Ideal input H = 1, P = 2, repeating: every commit gives 1/2. Without `clear`, `overrun` = 1 after the second commit. `clear` → both flags 0 next cycle.
- WIDTH = 8, input held high after one rise:
  - 255 cycles after the detected rise: `stuck` = 1, `stuck_level` = 1, `high_time` = 255, `period` = 255.
  - Next valid period clears `stuck`.
- Input high during and after reset, falls at cycle 10, rises at 20 and 50, falls at 30: the first commit gives H = 10, P = 30. No commit occurs before cycle 50 + SYNC_STAGES + 2.
- `clear` on the exact commit cycle with `new_data` = 1: `new_data` = 1, `overrun` = 0.
- `rst` asserted in LOW: all outputs 0 next cycle. The next commit requires two fresh rises.
